// File: rtl/axi128_pkg.sv
// Shared widths, response codes and FSM state types for the 128-bit AXI decoder.
package axi128_pkg;

    localparam int unsigned ADDR_W = 40;
    localparam int unsigned DATA_W = 128;
    localparam int unsigned STRB_W = 16;
    localparam int unsigned ID_W   = 8;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [0:0] {R_IDLE, R_BUSY} rd_state_e;
    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wr_state_e;

    // The window is aligned to its power-of-two size, so masking the offset bits suffices.
    function automatic logic addr_hit(input logic [ADDR_W-1:0] addr,
                                      input logic [ADDR_W-1:0] base,
                                      input logic [ADDR_W-1:0] size);
        return (addr & ~(size - ADDR_W'(1))) == base;
    endfunction

endpackage

// File: rtl/axi_dec128_wr.sv
// Write path of axi_dec128: AW/W/B routing and the write FSM.
// AXI_DEC128_DECERR_EN forces bresp_m to DECERR for responses from s1.
module axi_dec128_wr
    import axi128_pkg::*;
#(
    parameter logic [ADDR_W-1:0] MEM_BASE = 40'h0,
    parameter logic [ADDR_W-1:0] MEM_SIZE = 40'h10_0000_0000
) (
    input  logic              pll_core_cpuclk,
    input  logic              pad_cpu_rst,
    input  logic [ADDR_W-1:0] awaddr_m,
    input  logic [1:0]        awburst_m,
    input  logic [3:0]        awcache_m,
    input  logic [ID_W-1:0]   awid_m,
    input  logic [7:0]        awlen_m,
    input  logic [2:0]        awprot_m,
    input  logic [2:0]        awsize_m,
    input  logic              awvalid_m,
    output logic              awready_m,
    input  logic [DATA_W-1:0] wdata_m,
    input  logic [STRB_W-1:0] wstrb_m,
    input  logic [ID_W-1:0]   wid_m,
    input  logic              wlast_m,
    input  logic              wvalid_m,
    output logic              wready_m,
    output logic [ID_W-1:0]   bid_m,
    output logic [1:0]        bresp_m,
    output logic              bvalid_m,
    input  logic              bready_m,
    output logic [ADDR_W-1:0] awaddr_s0,
    output logic [1:0]        awburst_s0,
    output logic [3:0]        awcache_s0,
    output logic [ID_W-1:0]   awid_s0,
    output logic [7:0]        awlen_s0,
    output logic [2:0]        awprot_s0,
    output logic [2:0]        awsize_s0,
    output logic              awvalid_s0,
    input  logic              awready_s0,
    output logic [DATA_W-1:0] wdata_s0,
    output logic [STRB_W-1:0] wstrb_s0,
    output logic [ID_W-1:0]   wid_s0,
    output logic              wlast_s0,
    output logic              wvalid_s0,
    input  logic              wready_s0,
    input  logic [ID_W-1:0]   bid_s0,
    input  logic [1:0]        bresp_s0,
    input  logic              bvalid_s0,
    output logic              bready_s0,
    output logic [ADDR_W-1:0] awaddr_s1,
    output logic [1:0]        awburst_s1,
    output logic [3:0]        awcache_s1,
    output logic [ID_W-1:0]   awid_s1,
    output logic [7:0]        awlen_s1,
    output logic [2:0]        awprot_s1,
    output logic [2:0]        awsize_s1,
    output logic              awvalid_s1,
    input  logic              awready_s1,
    output logic [DATA_W-1:0] wdata_s1,
    output logic [STRB_W-1:0] wstrb_s1,
    output logic [ID_W-1:0]   wid_s1,
    output logic              wlast_s1,
    output logic              wvalid_s1,
    input  logic              wready_s1,
    input  logic [ID_W-1:0]   bid_s1,
    input  logic [1:0]        bresp_s1,
    input  logic              bvalid_s1,
    output logic              bready_s1
);

    wr_state_e wstate_q, wstate_d;
    logic      wsel_q, wsel_d;
    logic      aw_sel1, w_idle, w_data, w_resp;

    assign awaddr_s0  = awaddr_m;
    assign awburst_s0 = awburst_m;
    assign awcache_s0 = awcache_m;
    assign awid_s0    = awid_m;
    assign awlen_s0   = awlen_m;
    assign awprot_s0  = awprot_m;
    assign awsize_s0  = awsize_m;
    assign awaddr_s1  = awaddr_m;
    assign awburst_s1 = awburst_m;
    assign awcache_s1 = awcache_m;
    assign awid_s1    = awid_m;
    assign awlen_s1   = awlen_m;
    assign awprot_s1  = awprot_m;
    assign awsize_s1  = awsize_m;
    assign wdata_s0   = wdata_m;
    assign wstrb_s0   = wstrb_m;
    assign wid_s0     = wid_m;
    assign wlast_s0   = wlast_m;
    assign wdata_s1   = wdata_m;
    assign wstrb_s1   = wstrb_m;
    assign wid_s1     = wid_m;
    assign wlast_s1   = wlast_m;

    always_comb begin
        wstate_d = wstate_q;
        wsel_d   = wsel_q;
        aw_sel1  = ~addr_hit(awaddr_m, MEM_BASE, MEM_SIZE);
        // Reset masks every handshake output, whatever the state register holds.
        w_idle   = (wstate_q == W_IDLE) & ~pad_cpu_rst;
        w_data   = (wstate_q == W_DATA) & ~pad_cpu_rst;
        w_resp   = (wstate_q == W_RESP) & ~pad_cpu_rst;

        awvalid_s0 = awvalid_m & w_idle & ~aw_sel1;
        awvalid_s1 = awvalid_m & w_idle & aw_sel1;
        awready_m  = w_idle & (aw_sel1 ? awready_s1 : awready_s0);

        wvalid_s0 = wvalid_m & w_data & ~wsel_q;
        wvalid_s1 = wvalid_m & w_data & wsel_q;
        wready_m  = w_data & (wsel_q ? wready_s1 : wready_s0);

        bvalid_m  = w_resp & (wsel_q ? bvalid_s1 : bvalid_s0);
        bid_m     = wsel_q ? bid_s1 : bid_s0;
        bresp_m   = wsel_q ? bresp_s1 : bresp_s0;
`ifdef AXI_DEC128_DECERR_EN
        if (wsel_q) bresp_m = RESP_DECERR;
`endif
        bready_s0 = bready_m & w_resp & ~wsel_q;
        bready_s1 = bready_m & w_resp & wsel_q;

        case (wstate_q)
            W_IDLE: if (awvalid_m && awready_m) begin
                wstate_d = W_DATA;
                wsel_d   = aw_sel1;
            end
            W_DATA: if (wvalid_m && wready_m && wlast_m) wstate_d = W_RESP;
            W_RESP: if (bvalid_m && bready_m) wstate_d = W_IDLE;
            default: wstate_d = W_IDLE;
        endcase
    end

    always_ff @(posedge pll_core_cpuclk) begin
        if (pad_cpu_rst) begin
            wstate_q <= W_IDLE;
            wsel_q   <= 1'b0;
        end else begin
            wstate_q <= wstate_d;
            wsel_q   <= wsel_d;
        end
    end

endmodule

// File: rtl/axi_dec128.sv
// Single-master, two-slave AXI decoder: memory window to s0, everything else to s1.
// AXI_DEC128_DECERR_EN overrides s1 responses with DECERR and zero read data.
module axi_dec128
    import axi128_pkg::*;
#(
    parameter logic [ADDR_W-1:0] MEM_BASE = 40'h0,
    parameter logic [ADDR_W-1:0] MEM_SIZE = 40'h10_0000_0000
) (
    input  logic              pll_core_cpuclk,
    input  logic              pad_cpu_rst,
    input  logic [ADDR_W-1:0] araddr_m,
    input  logic [1:0]        arburst_m,
    input  logic [3:0]        arcache_m,
    input  logic [ID_W-1:0]   arid_m,
    input  logic [7:0]        arlen_m,
    input  logic [2:0]        arprot_m,
    input  logic [2:0]        arsize_m,
    input  logic              arvalid_m,
    output logic              arready_m,
    input  logic [ADDR_W-1:0] awaddr_m,
    input  logic [1:0]        awburst_m,
    input  logic [3:0]        awcache_m,
    input  logic [ID_W-1:0]   awid_m,
    input  logic [7:0]        awlen_m,
    input  logic [2:0]        awprot_m,
    input  logic [2:0]        awsize_m,
    input  logic              awvalid_m,
    output logic              awready_m,
    input  logic [DATA_W-1:0] wdata_m,
    input  logic [STRB_W-1:0] wstrb_m,
    input  logic [ID_W-1:0]   wid_m,
    input  logic              wlast_m,
    input  logic              wvalid_m,
    output logic              wready_m,
    output logic [DATA_W-1:0] rdata_m,
    output logic [ID_W-1:0]   rid_m,
    output logic [1:0]        rresp_m,
    output logic              rlast_m,
    output logic              rvalid_m,
    input  logic              rready_m,
    output logic [ID_W-1:0]   bid_m,
    output logic [1:0]        bresp_m,
    output logic              bvalid_m,
    input  logic              bready_m,
    output logic [ADDR_W-1:0] araddr_s0,
    output logic [1:0]        arburst_s0,
    output logic [3:0]        arcache_s0,
    output logic [ID_W-1:0]   arid_s0,
    output logic [7:0]        arlen_s0,
    output logic [2:0]        arprot_s0,
    output logic [2:0]        arsize_s0,
    output logic              arvalid_s0,
    input  logic              arready_s0,
    output logic [ADDR_W-1:0] awaddr_s0,
    output logic [1:0]        awburst_s0,
    output logic [3:0]        awcache_s0,
    output logic [ID_W-1:0]   awid_s0,
    output logic [7:0]        awlen_s0,
    output logic [2:0]        awprot_s0,
    output logic [2:0]        awsize_s0,
    output logic              awvalid_s0,
    input  logic              awready_s0,
    output logic [DATA_W-1:0] wdata_s0,
    output logic [STRB_W-1:0] wstrb_s0,
    output logic [ID_W-1:0]   wid_s0,
    output logic              wlast_s0,
    output logic              wvalid_s0,
    input  logic              wready_s0,
    input  logic [DATA_W-1:0] rdata_s0,
    input  logic [ID_W-1:0]   rid_s0,
    input  logic [1:0]        rresp_s0,
    input  logic              rlast_s0,
    input  logic              rvalid_s0,
    output logic              rready_s0,
    input  logic [ID_W-1:0]   bid_s0,
    input  logic [1:0]        bresp_s0,
    input  logic              bvalid_s0,
    output logic              bready_s0,
    output logic [ADDR_W-1:0] araddr_s1,
    output logic [1:0]        arburst_s1,
    output logic [3:0]        arcache_s1,
    output logic [ID_W-1:0]   arid_s1,
    output logic [7:0]        arlen_s1,
    output logic [2:0]        arprot_s1,
    output logic [2:0]        arsize_s1,
    output logic              arvalid_s1,
    input  logic              arready_s1,
    output logic [ADDR_W-1:0] awaddr_s1,
    output logic [1:0]        awburst_s1,
    output logic [3:0]        awcache_s1,
    output logic [ID_W-1:0]   awid_s1,
    output logic [7:0]        awlen_s1,
    output logic [2:0]        awprot_s1,
    output logic [2:0]        awsize_s1,
    output logic              awvalid_s1,
    input  logic              awready_s1,
    output logic [DATA_W-1:0] wdata_s1,
    output logic [STRB_W-1:0] wstrb_s1,
    output logic [ID_W-1:0]   wid_s1,
    output logic              wlast_s1,
    output logic              wvalid_s1,
    input  logic              wready_s1,
    input  logic [DATA_W-1:0] rdata_s1,
    input  logic [ID_W-1:0]   rid_s1,
    input  logic [1:0]        rresp_s1,
    input  logic              rlast_s1,
    input  logic              rvalid_s1,
    output logic              rready_s1,
    input  logic [ID_W-1:0]   bid_s1,
    input  logic [1:0]        bresp_s1,
    input  logic              bvalid_s1,
    output logic              bready_s1
);

    rd_state_e rstate_q, rstate_d;
    logic      rsel_q, rsel_d;
    logic      ar_sel1, r_idle, r_busy;

    assign araddr_s0  = araddr_m;
    assign arburst_s0 = arburst_m;
    assign arcache_s0 = arcache_m;
    assign arid_s0    = arid_m;
    assign arlen_s0   = arlen_m;
    assign arprot_s0  = arprot_m;
    assign arsize_s0  = arsize_m;
    assign araddr_s1  = araddr_m;
    assign arburst_s1 = arburst_m;
    assign arcache_s1 = arcache_m;
    assign arid_s1    = arid_m;
    assign arlen_s1   = arlen_m;
    assign arprot_s1  = arprot_m;
    assign arsize_s1  = arsize_m;

    always_comb begin
        rstate_d = rstate_q;
        rsel_d   = rsel_q;
        ar_sel1  = ~addr_hit(araddr_m, MEM_BASE, MEM_SIZE);
        r_idle   = (rstate_q == R_IDLE) & ~pad_cpu_rst;
        r_busy   = (rstate_q == R_BUSY) & ~pad_cpu_rst;

        arvalid_s0 = arvalid_m & r_idle & ~ar_sel1;
        arvalid_s1 = arvalid_m & r_idle & ar_sel1;
        arready_m  = r_idle & (ar_sel1 ? arready_s1 : arready_s0);

        rvalid_m  = r_busy & (rsel_q ? rvalid_s1 : rvalid_s0);
        rdata_m   = rsel_q ? rdata_s1 : rdata_s0;
        rid_m     = rsel_q ? rid_s1 : rid_s0;
        rresp_m   = rsel_q ? rresp_s1 : rresp_s0;
        rlast_m   = rsel_q ? rlast_s1 : rlast_s0;
`ifdef AXI_DEC128_DECERR_EN
        if (rsel_q) begin
            rresp_m = RESP_DECERR;
            rdata_m = '0;
        end
`endif
        rready_s0 = rready_m & r_busy & ~rsel_q;
        rready_s1 = rready_m & r_busy & rsel_q;

        case (rstate_q)
            R_IDLE: if (arvalid_m && arready_m) begin
                rstate_d = R_BUSY;
                rsel_d   = ar_sel1;
            end
            R_BUSY: if (rvalid_m && rready_m && rlast_m) rstate_d = R_IDLE;
            default: rstate_d = R_IDLE;
        endcase
    end

    always_ff @(posedge pll_core_cpuclk) begin
        if (pad_cpu_rst) begin
            rstate_q <= R_IDLE;
            rsel_q   <= 1'b0;
        end else begin
            rstate_q <= rstate_d;
            rsel_q   <= rsel_d;
        end
    end

    axi_dec128_wr #(
        .MEM_BASE (MEM_BASE),
        .MEM_SIZE (MEM_SIZE)
    ) u_wr (.*);

endmodule
